// File: rtl/systolic_pkg.sv
// systolic_pkg: shared types, defaults and index helper for the systolic result-drain path
package systolic_pkg;
   typedef enum logic {ST_IDLE = 1'b0, ST_STREAM = 1'b1} state_t;
   localparam int DEF_N = 4;
   localparam int DEF_ACC_W = 32;
   function automatic int flat_idx(input int r, input int c, input int n);
      return r * n + c;
   endfunction
endpackage

// File: rtl/acc_snapshot_bank.sv
// acc_snapshot_bank: N*N accumulator snapshot registers with load strobe and indexed read
module acc_snapshot_bank
   import systolic_pkg::*;
#(
   parameter int N = DEF_N,
   parameter int ACC_W = DEF_ACC_W,
   parameter int IDX_W = $clog2(N*N)
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 load_i,
   input  logic [N*N*ACC_W-1:0] acc_flat_i,
   input  logic [IDX_W-1:0]     idx_i,
   output logic [ACC_W-1:0]     rd_o
);
   logic [ACC_W-1:0] bank_q [N*N];
   for (genvar r = 0; r < N; r++) begin : g_row
      for (genvar c = 0; c < N; c++) begin : g_col
         localparam int K = flat_idx(r, c, N);
         always_ff @(posedge clk) begin
            if (!reset_n) bank_q[K] <= '0;
            else if (load_i) bank_q[K] <= acc_flat_i[K*ACC_W +: ACC_W];
         end
      end
   end
   always_comb rd_o = bank_q[idx_i];
endmodule

// File: rtl/systolic_acc_drain.sv
// systolic_acc_drain: snapshots PE accumulators on done and streams them out row-major
module systolic_acc_drain
   import systolic_pkg::*;
#(
   parameter int N = DEF_N,
   parameter int ACC_W = DEF_ACC_W,
   parameter int IDX_W = $clog2(N*N)
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [N*N*ACC_W-1:0] acc_flat,
   input  logic                 done_in,
   output logic                 pe_clear,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic [ACC_W-1:0]     m_data,
   output logic [IDX_W-1:0]     m_index,
   output logic                 m_last,
   output logic                 busy,
   output logic                 overrun
);
   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             clr_q, clr_d, ovr_q, ovr_d;
   logic             last, fin, accept;
   logic [ACC_W-1:0] rd;
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         clr_q   <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         clr_q   <= clr_d;
         ovr_q   <= ovr_d;
      end
   end
   // a done coinciding with the final handshake is taken back-to-back, otherwise it is an overrun
   always_comb begin
      last    = idx_q == IDX_W'(N*N-1);
      fin     = (state_q == ST_STREAM) & m_ready & last;
      accept  = done_in & ((state_q == ST_IDLE) | fin);
      state_d = accept ? ST_STREAM : fin ? ST_IDLE : state_q;
      idx_d   = (accept | fin) ? '0 : ((state_q == ST_STREAM) & m_ready) ? idx_q + IDX_W'(1) : idx_q;
      clr_d   = accept;
      ovr_d   = ovr_q | (done_in & (state_q == ST_STREAM) & ~fin);
   end
   always_comb begin
      m_valid  = state_q == ST_STREAM;
      busy     = state_q == ST_STREAM;
      m_data   = (state_q == ST_STREAM) ? rd : '0;
      m_index  = idx_q;
      m_last   = (state_q == ST_STREAM) & last;
      pe_clear = clr_q;
      overrun  = ovr_q;
   end
   acc_snapshot_bank #(.N(N), .ACC_W(ACC_W), .IDX_W(IDX_W)) u_bank (
      .clk        (clk),
      .reset_n    (reset_n),
      .load_i     (accept),
      .acc_flat_i (acc_flat),
      .idx_i      (idx_q),
      .rd_o       (rd)
   );
endmodule

// File: tb/tb_systolic_acc_drain.sv
// tb_systolic_acc_drain: directed-vector bench for the N=2 result drain
module tb_systolic_acc_drain;
   localparam int N = 2;
   localparam int ACC_W = 32;
   localparam int IDX_W = 2;
   logic                 clk = 1'b0;
   logic                 reset_n = 1'b0;
   logic [N*N*ACC_W-1:0] acc_flat = '0;
   logic                 done_in = 1'b0;
   logic                 m_ready = 1'b0;
   logic                 pe_clear, m_valid, m_last, busy, overrun;
   logic [ACC_W-1:0]     m_data;
   logic [IDX_W-1:0]     m_index;
   int                   n_tests = 0;
   int                   n_fail = 0;
   always #5 clk = ~clk;
   systolic_acc_drain #(.N(N), .ACC_W(ACC_W)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .acc_flat (acc_flat),
      .done_in  (done_in),
      .pe_clear (pe_clear),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .m_data   (m_data),
      .m_index  (m_index),
      .m_last   (m_last),
      .busy     (busy),
      .overrun  (overrun)
   );
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic set_acc(input logic [31:0] a0, a1, a2, a3);
      acc_flat = {a3, a2, a1, a0};
   endtask
   task automatic test_reset();
      reset_n = 1'b0;
      done_in = 1'b1;
      set_acc(10, 20, 30, 40);
      tick();
      tick();
      n_tests++;
      if ({m_valid, m_data, m_index, m_last, busy, pe_clear, overrun} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: v=%b d=%0h i=%0d l=%b b=%b c=%b o=%b, need all 0",
                  m_valid, m_data, m_index, m_last, busy, pe_clear, overrun);
      end
      reset_n = 1'b1;
      done_in = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         n_tests++;
         if (m_valid !== 1'b0 || busy !== 1'b0 || pe_clear !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle cyc=%0d: v=%b b=%b c=%b, need 0 0 0", k, m_valid, busy, pe_clear);
         end
      end
   endtask
   task automatic test_basic();
      set_acc(10, 20, 30, 40);
      m_ready = 1'b1;
      done_in = 1'b1;
      tick();
      done_in = 1'b0;
      for (int k = 0; k < 4; k++) begin
         n_tests++;
         if (m_valid !== 1'b1 || busy !== 1'b1 || m_data !== 32'(10*(k+1)) || m_index !== IDX_W'(k)
             || m_last !== (k == 3) || pe_clear !== (k == 0)) begin
            n_fail++;
            $display("FAIL basic_word k=%0d: v=%b b=%b d=%0d i=%0d l=%b c=%b, need 1 1 %0d %0d %b %b",
                     k, m_valid, busy, m_data, m_index, m_last, pe_clear, 10*(k+1), k, k == 3, k == 0);
         end
         tick();
      end
      n_tests++;
      if (busy !== 1'b0 || m_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_end: b=%b v=%b, need 0 0", busy, m_valid);
      end
   endtask
   task automatic test_backpressure();
      set_acc(10, 20, 30, 40);
      m_ready = 1'b0;
      done_in = 1'b1;
      tick();
      done_in = 1'b0;
      for (int c = 0; c < 8; c++) begin
         n_tests++;
         if (m_valid !== 1'b1 || m_data !== 32'(10*(c/2+1)) || m_index !== IDX_W'(c/2)
             || m_last !== (c/2 == 3) || pe_clear !== (c == 0)) begin
            n_fail++;
            $display("FAIL bp_word c=%0d: v=%b d=%0d i=%0d l=%b c=%b, need 1 %0d %0d %b %b",
                     c, m_valid, m_data, m_index, m_last, pe_clear, 10*(c/2+1), c/2, c/2 == 3, c == 0);
         end
         m_ready = c[0];
         tick();
      end
      n_tests++;
      if (busy !== 1'b0 || m_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_end: b=%b v=%b, need 0 0", busy, m_valid);
      end
      m_ready = 1'b1;
   endtask
   task automatic test_isolation();
      set_acc(10, 20, 30, 40);
      m_ready = 1'b1;
      done_in = 1'b1;
      tick();
      done_in = 1'b0;
      set_acc(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      for (int k = 0; k < 4; k++) begin
         n_tests++;
         if (m_valid !== 1'b1 || m_data !== 32'(10*(k+1)) || m_index !== IDX_W'(k)) begin
            n_fail++;
            $display("FAIL iso_word k=%0d: v=%b d=%0h i=%0d, need 1 %0h %0d",
                     k, m_valid, m_data, m_index, 10*(k+1), k);
         end
         tick();
      end
   endtask
   task automatic test_overrun_b2b();
      set_acc(10, 20, 30, 40);
      m_ready = 1'b1;
      done_in = 1'b1;
      tick();
      done_in = 1'b0;
      n_tests++;
      if (overrun !== 1'b0 || m_index !== 2'd0) begin
         n_fail++;
         $display("FAIL ovr_pre: o=%b i=%0d, need 0 0", overrun, m_index);
      end
      tick();
      set_acc(5, 6, 7, 8);
      done_in = 1'b1;
      tick();
      done_in = 1'b0;
      n_tests++;
      if (overrun !== 1'b1 || pe_clear !== 1'b0 || m_data !== 32'd30 || m_index !== 2'd2) begin
         n_fail++;
         $display("FAIL ovr_set: o=%b c=%b d=%0d i=%0d, need 1 0 30 2", overrun, pe_clear, m_data, m_index);
      end
      tick();
      n_tests++;
      if (m_data !== 32'd40 || m_last !== 1'b1 || overrun !== 1'b1) begin
         n_fail++;
         $display("FAIL ovr_last: d=%0d l=%b o=%b, need 40 1 1", m_data, m_last, overrun);
      end
      done_in = 1'b1;
      tick();
      done_in = 1'b0;
      n_tests++;
      if (m_valid !== 1'b1 || m_index !== 2'd0 || m_data !== 32'd5 || pe_clear !== 1'b1 || overrun !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_start: v=%b i=%0d d=%0d c=%b o=%b, need 1 0 5 1 1",
                  m_valid, m_index, m_data, pe_clear, overrun);
      end
      for (int k = 1; k < 4; k++) begin
         tick();
         n_tests++;
         if (m_valid !== 1'b1 || m_data !== 32'(k+5) || m_index !== IDX_W'(k) || pe_clear !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_word k=%0d: v=%b d=%0d i=%0d c=%b, need 1 %0d %0d 0",
                     k, m_valid, m_data, m_index, pe_clear, k+5, k);
         end
      end
      tick();
      n_tests++;
      if (busy !== 1'b0 || overrun !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_end: b=%b o=%b, need 0 1", busy, overrun);
      end
   endtask
   task automatic test_reset_mid();
      set_acc(10, 20, 30, 40);
      m_ready = 1'b1;
      done_in = 1'b1;
      tick();
      done_in = 1'b0;
      tick();
      tick();
      n_tests++;
      if (m_index !== 2'd2 || m_data !== 32'd30) begin
         n_fail++;
         $display("FAIL mid_pre: i=%0d d=%0d, need 2 30", m_index, m_data);
      end
      reset_n = 1'b0;
      tick();
      n_tests++;
      if (m_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0 || m_data !== '0 || m_index !== '0) begin
         n_fail++;
         $display("FAIL mid_reset: v=%b b=%b o=%b d=%0d i=%0d, need 0 0 0 0 0",
                  m_valid, busy, overrun, m_data, m_index);
      end
      reset_n = 1'b1;
      tick();
      n_tests++;
      if (m_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_idle: v=%b, need 0", m_valid);
      end
      done_in = 1'b1;
      tick();
      done_in = 1'b0;
      for (int k = 0; k < 4; k++) begin
         n_tests++;
         if (m_valid !== 1'b1 || m_data !== 32'(10*(k+1)) || m_index !== IDX_W'(k) || pe_clear !== (k == 0)) begin
            n_fail++;
            $display("FAIL mid_restart k=%0d: v=%b d=%0d i=%0d c=%b, need 1 %0d %0d %b",
                     k, m_valid, m_data, m_index, pe_clear, 10*(k+1), k, k == 0);
         end
         tick();
      end
   endtask
   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_isolation();
      test_overrun_b2b();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
